// File: rtl/gate_net_infer_pipe.sv
// Programmable two-layer 3-input gate network classifier with a 4-stage valid/ready pipeline.
// Define SCORE_OUT_EN to expose the per-class vote scores on out_scores.
`timescale 1ns/1ps
module gate_net_infer_pipe #(
  parameter int N_IN  = 49,
  parameter int N_L1  = 24,
  parameter int N_CLS = 2,
  parameter int G_CLS = 4,
  parameter int CNT_W = 16,
  localparam int N_G   = N_L1 + N_CLS * G_CLS,
  localparam int SRC_N = N_IN + 2 + N_L1,
  localparam int SW    = $clog2(SRC_N),
  localparam int CW    = $clog2(G_CLS + 1),
  localparam int AW    = $clog2(N_G),
  localparam int CLS_W = $clog2(N_CLS),
  localparam int CFG_W = 3 + 3 * SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_busy,
  output logic [CNT_W-1:0]  infer_cnt
`ifdef SCORE_OUT_EN
  ,
  output logic [N_CLS*CW-1:0] out_scores
`endif
);

  localparam int N_O = N_CLS * G_CLS;

  logic [CFG_W-1:0]    cfg_mem [N_G];
  logic                advance, accept, addr_ok, wr_ok;
  logic                pend_vld, pend_l1, pend_commit;
  logic [AW-1:0]       pend_addr;
  logic [CFG_W-1:0]    pend_data;
  logic                vld_p0, vld_p1, vld_p2;
  logic                tag_p0, tag_p1;
  logic [N_IN-1:0]     in_p0, in_p1;
  logic [N_L1-1:0]     l1_d, l1_p1;
  logic [N_O-1:0]      og_d, og_p2;
  logic [N_CLS*CW-1:0] score_d;

  function automatic logic pick(input logic [SRC_N-1:0] v, input logic [SW-1:0] idx);
    logic [(1<<SW)-1:0] pv;
    pv = '0;
    pv[SRC_N-1:0] = v;
    return pv[idx];
  endfunction

  function automatic logic gate_eval(input logic [CFG_W-1:0] cfg, input logic [SRC_N-1:0] v);
    logic a, b, c;
    a = pick(v, cfg[3*SW-1 -: SW]);
    b = pick(v, cfg[2*SW-1 -: SW]);
    c = pick(v, cfg[SW-1:0]);
    case (cfg[CFG_W-1 -: 3])
      3'd0:    gate_eval = 1'b0;
      3'd1:    gate_eval = 1'b1;
      3'd2:    gate_eval = a & b;
      3'd3:    gate_eval = a | b;
      3'd4:    gate_eval = a ^ b;
      3'd5:    gate_eval = a & b & c;
      3'd6:    gate_eval = (a & b) | (a & c) | (b & c);
      default: gate_eval = a | b | c;
    endcase
  endfunction

  // strict '>' keeps the lowest class index on ties
  function automatic logic [CLS_W-1:0] argmax(input logic [N_CLS*CW-1:0] s);
    logic [CW-1:0] best;
    best   = s[CW-1:0];
    argmax = '0;
    for (int c = 1; c < N_CLS; c++) begin
      if (s[c*CW +: CW] > best) begin
        best   = s[c*CW +: CW];
        argmax = CLS_W'(c);
      end
    end
  endfunction

  generate
    if (N_G == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (cfg_addr < AW'(N_G));
    end
  endgenerate

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign cfg_busy = vld_p0 | vld_p1 | vld_p2 | out_valid;
  assign wr_ok    = cfg_we & !cfg_busy & addr_ok;

  // A write coinciding with an accepted sample is parked until that sample has
  // evaluated the targeted layer, so it sees the old config and its successor the new one.
  assign pend_l1     = (pend_addr < AW'(N_L1));
  assign pend_commit = pend_vld & advance & (pend_l1 ? tag_p0 : tag_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < N_G; g++) cfg_mem[g] <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (wr_ok && !accept) cfg_mem[cfg_addr] <= cfg_data;
      if (wr_ok && accept) begin
        pend_vld <= 1'b1;
      end else if (pend_commit) begin
        cfg_mem[pend_addr] <= pend_data;
        pend_vld           <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && accept) begin
      pend_addr <= cfg_addr;
      pend_data <= cfg_data;
    end
  end

  always_comb begin
    l1_d    = '0;
    og_d    = '0;
    score_d = '0;
    for (int k = 0; k < N_L1; k++)
      l1_d[k] = gate_eval(cfg_mem[k], {{N_L1{1'b0}}, 1'b0, 1'b1, in_p0});
    for (int j = 0; j < N_O; j++)
      og_d[j] = gate_eval(cfg_mem[N_L1+j], {l1_p1, 1'b0, 1'b1, in_p1});
    for (int c = 0; c < N_CLS; c++)
      for (int j = 0; j < G_CLS; j++)
        score_d[c*CW +: CW] = score_d[c*CW +: CW] + CW'(og_p2[c*G_CLS+j]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      tag_p0    <= 1'b0;
      tag_p1    <= 1'b0;
      out_class <= '0;
      infer_cnt <= '0;
`ifdef SCORE_OUT_EN
      out_scores <= '0;
`endif
    end else begin
      if (advance) begin
        vld_p0    <= in_valid;
        tag_p0    <= in_valid & wr_ok;
        vld_p1    <= vld_p0;
        tag_p1    <= tag_p0;
        vld_p2    <= vld_p1;
        out_valid <= vld_p2;
        if (vld_p2) begin
          out_class <= argmax(score_d);
`ifdef SCORE_OUT_EN
          out_scores <= score_d;
`endif
        end
      end
      if (out_valid && out_ready) infer_cnt <= infer_cnt + CNT_W'(1);
    end
  end

  // S0 input reg -> S1 layer-1 reg -> S2 output-gate reg; S3 result lives above
  always_ff @(posedge clk) begin
    if (advance) begin
      in_p0 <= in_bits;
      in_p1 <= in_p0;
      l1_p1 <= l1_d;
      og_p2 <= og_d;
    end
  end

endmodule

// File: tb/tb_gate_net_infer_pipe.sv
// Scoreboard bench for gate_net_infer_pipe: randomized samples against a behavioural network model.
`timescale 1ns/1ps
module tb_gate_net_infer_pipe;
  localparam int N_IN  = 49;
  localparam int N_L1  = 24;
  localparam int N_CLS = 2;
  localparam int G_CLS = 4;
  localparam int CNT_W = 16;
  localparam int N_G   = N_L1 + N_CLS * G_CLS;
  localparam int SW    = $clog2(N_IN + 2 + N_L1);
  localparam int CW    = $clog2(G_CLS + 1);
  localparam int AW    = $clog2(N_G);
  localparam int CLS_W = $clog2(N_CLS);
  localparam int CD    = 3 + 3 * SW;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_bits;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CLS_W-1:0]  out_class;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CD-1:0]     cfg_data;
  logic              cfg_busy;
  logic [CNT_W-1:0]  infer_cnt;
`ifdef SCORE_OUT_EN
  logic [N_CLS*CW-1:0] out_scores;
`endif

  gate_net_infer_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .infer_cnt(infer_cnt)
`ifdef SCORE_OUT_EN
    , .out_scores(out_scores)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  cls;
    logic [N_CLS*CW-1:0] sc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   hs = 0;
  bit   stall = 1'b0;
  bit   rand_rdy = 1'b0;
  int   m_op [N_G];
  int   m_a  [N_G];
  int   m_b  [N_G];
  int   m_c  [N_G];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: gate truth by counting ones, sources decoded from the index map.
  function automatic int gate_fn(input int op, input int a, input int b, input int c);
    int s;
    s = a + b + c;
    case (op)
      0: return 0;
      1: return 1;
      2: return (a + b == 2) ? 1 : 0;
      3: return (a + b >= 1) ? 1 : 0;
      4: return (a + b == 1) ? 1 : 0;
      5: return (s == 3) ? 1 : 0;
      6: return (s >= 2) ? 1 : 0;
      default: return (s >= 1) ? 1 : 0;
    endcase
  endfunction

  function automatic int sv(input logic [N_IN-1:0] x, input int idx,
                            input logic [N_L1-1:0] l1v, input bit use_l1);
    if (idx < N_IN) return x[idx] ? 1 : 0;
    if (idx == N_IN) return 1;
    if (idx == N_IN + 1) return 0;
    if (use_l1 && idx < N_IN + 2 + N_L1) return l1v[idx-N_IN-2] ? 1 : 0;
    return 0;
  endfunction

  function automatic exp_t model(input logic [N_IN-1:0] x);
    exp_t            e;
    logic [N_L1-1:0] l1v;
    int              s, best, g;
    l1v = '0;
    for (int k = 0; k < N_L1; k++)
      l1v[k] = gate_fn(m_op[k], sv(x, m_a[k], l1v, 1'b0), sv(x, m_b[k], l1v, 1'b0),
                       sv(x, m_c[k], l1v, 1'b0)) != 0;
    e.cls = 0;
    e.sc  = '0;
    best  = -1;
    for (int c = 0; c < N_CLS; c++) begin
      s = 0;
      for (int j = 0; j < G_CLS; j++) begin
        g = N_L1 + c * G_CLS + j;
        s += gate_fn(m_op[g], sv(x, m_a[g], l1v, 1'b1), sv(x, m_b[g], l1v, 1'b1),
                     sv(x, m_c[g], l1v, 1'b1));
      end
      e.sc[c*CW +: CW] = CW'(s);
      if (s > best) begin
        best  = s;
        e.cls = c;
      end
    end
    return e;
  endfunction

  function automatic void model_clear();
    for (int g = 0; g < N_G; g++) begin
      m_op[g] = 0; m_a[g] = 0; m_b[g] = 0; m_c[g] = 0;
    end
  endfunction

  function automatic logic [N_IN-1:0] rand_x();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[N_IN-1:0];
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      check("output_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_class", 64'(out_class), 64'(e.cls));
`ifdef SCORE_OUT_EN
        check("out_scores", 64'(out_scores), 64'(e.sc));
`endif
        hs++;
      end
    end
  end

  task automatic send(input logic [N_IN-1:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_bits  = x;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accepted", 64'(in_ready), 64'd1);
    if (in_ready) q.push_back(model(x));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (q.size() != 0 && i < 400) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_done", 64'(q.size()), 64'd0);
    check("idle_cfg_busy", 64'(cfg_busy), 64'd0);
  endtask

  task automatic cfg_write(input int addr, input int op, input int a, input int b, input int c);
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = {3'(op), SW'(a), SW'(b), SW'(c)};
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_op[addr] = op; m_a[addr] = a; m_b[addr] = b; m_c[addr] = c;
  endtask

  task automatic random_cfg();
    for (int g = 0; g < N_G; g++)
      cfg_write(g, int'($urandom_range(0, 7)), int'($urandom_range(0, 80)),
                int'($urandom_range(0, 80)), int'($urandom_range(0, 80)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt0;
    rst = 1'b1; in_valid = 1'b0; in_bits = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
    check("rst_infer_cnt", 64'(infer_cnt), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
`ifdef SCORE_OUT_EN
    check("rst_out_scores", 64'(out_scores), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency 3 with unconfigured (all CONST0) network
    send(49'h1);
    repeat (3) begin
      @(negedge clk);
      check("latency_early", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("latency_k3", 64'(out_valid), 64'd1);
    drain();
    check("infer_cnt_first", 64'(infer_cnt), 64'd1);

    // L1[0] = in0 ^ in1; class1 gate0 = L1[0] & const1
    cfg_write(0, 4, 0, 1, 0);
    cfg_write(N_L1 + G_CLS, 2, N_IN + 2, N_IN, 0);
    send(49'b01);
    send(49'b11);
    send(49'b10);
    drain();

    // Tie between two classes of two CONST1 votes each
    cfg_write(N_L1, 1, 0, 0, 0);
    cfg_write(N_L1 + 1, 1, 0, 0, 0);
    cfg_write(N_L1 + G_CLS, 1, 0, 0, 0);
    cfg_write(N_L1 + G_CLS + 1, 1, 0, 0, 0);
    send(rand_x());
    send(rand_x());
    drain();

    // Class1 gate0 = MAJ(in2, in3, in4), everything else at output CONST0
    cfg_write(N_L1, 0, 0, 0, 0);
    cfg_write(N_L1 + 1, 0, 0, 0, 0);
    cfg_write(N_L1 + G_CLS + 1, 0, 0, 0, 0);
    cfg_write(N_L1 + G_CLS, 6, 2, 3, 4);
    send(49'b01100);
    send(49'b00100);
    send(49'b10100);
    drain();

    // Write while busy must be dropped
    send(49'b01100);
    cfg_we = 1'b1; cfg_addr = AW'(N_L1 + G_CLS); cfg_data = '0;
    @(negedge clk);
    check("busy_during_write", 64'(cfg_busy), 64'd1);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    drain();
    send(49'b01100);
    drain();

    // Write together with an accept: that sample sees old config, the next one new
    in_valid = 1'b1; in_bits = 49'b01100;
    cfg_we = 1'b1; cfg_addr = AW'(N_L1 + G_CLS); cfg_data = '0;
    @(negedge clk);
    check("simul_in_ready", 64'(in_ready), 64'd1);
    q.push_back(model(in_bits));
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_op[N_L1+G_CLS] = 0; m_a[N_L1+G_CLS] = 0; m_b[N_L1+G_CLS] = 0; m_c[N_L1+G_CLS] = 0;
    @(negedge clk);
    check("simul_next_in_ready", 64'(in_ready), 64'd1);
    q.push_back(model(in_bits));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("infer_cnt_mid", 64'(infer_cnt), 64'(hs));

    // Burst of 8 with a 5-cycle output stall
    random_cfg();
    cnt0 = hs;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_x());
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    drain();
    check("burst_count", 64'(hs - cnt0), 64'd8);
    check("infer_cnt_burst", 64'(infer_cnt), 64'(hs));

    // Random stream with random back-pressure and input gaps
    random_cfg();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_x());
    end
    rand_rdy = 1'b0;
    drain();
    check("infer_cnt_random", 64'(infer_cnt), 64'(hs));

    // Reset with three samples in flight; class1 forced to win beforehand
    for (int j = 0; j < N_CLS * G_CLS; j++) cfg_write(N_L1 + j, (j == G_CLS) ? 1 : 0, 0, 0, 0);
    send(rand_x());
    send(rand_x());
    send(rand_x());
    #1;
    rst = 1'b1;
    #2;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_infer_cnt", 64'(infer_cnt), 64'd0);
    check("midrst_cfg_busy", 64'(cfg_busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_class", 64'(out_class), 64'd0);
    q.delete();
    model_clear();
    hs = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(rand_x());
    send(rand_x());
    send(rand_x());
    drain();
    check("infer_cnt_after_rst", 64'(infer_cnt), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
